// File: rtl/dino_jump_ctrl.sv
// Dino vertical-motion controller: button edge capture plus integer jump/fall physics on frame ticks.
// Optional feature macro: DINO_JUMP_CUT_EN (releasing jump while rising starts the fall early).
module dino_jump_ctrl #(
    parameter int unsigned Y_W      = 6,
    parameter int unsigned S_W      = 4,
    parameter int unsigned JUMP_VEL = 8,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           run,
    input  logic           jump_btn,
    input  logic           duck_btn,
    output logic [Y_W-1:0] dino_y,
    output logic           airborne,
    output logic           ducking,
    output logic           jump_pulse,
    output logic           land_pulse
);

    typedef enum logic [1:0] {GROUND, DUCK, RISING, FALLING} state_t;

`ifdef DINO_JUMP_CUT_EN
    localparam bit CUT_EN = 1'b1;
`else
    localparam bit CUT_EN = 1'b0;
`endif

    localparam int unsigned   C_W      = (Y_W > S_W + 1) ? Y_W : S_W + 1;
    localparam logic [S_W-1:0] JUMP_SPD = S_W'(JUMP_VEL);
    localparam logic [S_W-1:0] GRAV_SPD = S_W'(GRAVITY);
    localparam logic [S_W:0]   FALL_CAP = (S_W+1)'(MAX_FALL);

    // The apex of a full arc is the triangular sum of JUMP_VEL; it must fit in dino_y.
    if (JUMP_VEL * (JUMP_VEL + 1) / 2 >= 2 ** Y_W) begin : g_y_chk
        $error("dino_jump_ctrl: jump apex does not fit in Y_W bits");
    end
    if (GRAVITY < 1 || JUMP_VEL >= 2 ** S_W || MAX_FALL >= 2 ** S_W || GRAVITY >= 2 ** S_W) begin : g_s_chk
        $error("dino_jump_ctrl: speed parameters out of range for S_W");
    end

    state_t         state;
    logic [S_W-1:0] speed;
    logic           pending;
    logic           btn_q;

    logic           rise;
    logic [S_W:0]   fall_sum;
    logic [S_W-1:0] fall_spd;
    logic           land_now;
    logic [Y_W-1:0] rise_y;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        rise     = jump_btn & ~btn_q;
        fall_sum = {1'b0, speed} + (S_W+1)'(GRAVITY);
        fall_spd = (fall_sum > FALL_CAP) ? S_W'(MAX_FALL) : fall_sum[S_W-1:0];
        land_now = C_W'(dino_y) <= C_W'(fall_spd);
        rise_y   = dino_y + Y_W'(speed);
    end

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GROUND;
            dino_y     <= '0;
            speed      <= '0;
            pending    <= 1'b0;
            btn_q      <= 1'b0;
            jump_pulse <= 1'b0;
            land_pulse <= 1'b0;
        end else begin
            btn_q      <= jump_btn;
            jump_pulse <= 1'b0;
            land_pulse <= 1'b0;
            if (!run) begin
                pending <= 1'b0;
            end else begin
                if (rise) pending <= 1'b1;
                if (tick) begin
                    case (state)
                        GROUND: begin
                            if (pending || rise) begin
                                state      <= RISING;
                                speed      <= JUMP_SPD;
                                pending    <= 1'b0;
                                jump_pulse <= 1'b1;
                            end else if (duck_btn) begin
                                state <= DUCK;
                            end
                        end
                        DUCK: begin
                            pending <= 1'b0;
                            dino_y  <= '0;
                            if (!duck_btn) state <= GROUND;
                        end
                        RISING: begin
                            pending <= 1'b0;
                            if (CUT_EN && !jump_btn) begin
                                state <= FALLING;
                                speed <= '0;
                            end else begin
                                dino_y <= rise_y;
                                if (speed <= GRAV_SPD) begin
                                    state <= FALLING;
                                    speed <= '0;
                                end else begin
                                    speed <= speed - GRAV_SPD;
                                end
                            end
                        end
                        FALLING: begin
                            pending <= 1'b0;
                            if (land_now) begin
                                state      <= GROUND;
                                dino_y     <= '0;
                                speed      <= '0;
                                land_pulse <= 1'b1;
                            end else begin
                                dino_y <= dino_y - Y_W'(fall_spd);
                                speed  <= fall_spd;
                            end
                        end
                        default: state <= GROUND;
                    endcase
                end
            end
        end
    end

    assign airborne = (state == RISING) || (state == FALLING);
    assign ducking  = (state == DUCK);

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl: hand-computed arcs, duck, run freeze, reset, optional jump cut.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       run;
    logic       jump_btn;
    logic       duck_btn;
    logic [5:0] dino_y;
    logic       airborne;
    logic       ducking;
    logic       jump_pulse;
    logic       land_pulse;

    int tests  = 0;
    int errors = 0;

    dino_jump_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .run        (run),
        .jump_btn   (jump_btn),
        .duck_btn   (duck_btn),
        .dino_y     (dino_y),
        .airborne   (airborne),
        .ducking    (ducking),
        .jump_pulse (jump_pulse),
        .land_pulse (land_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One-clock tick; outputs are sampled on the falling edge after the ticked rising edge.
    task automatic tick1();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic launch(input string tag);
        @(negedge clk) jump_btn = 1'b1;
        tick1();
        check({tag, " launch pulse"}, jump_pulse, 1);
        check({tag, " launch air"}, airborne, 1);
        check({tag, " launch y"}, dino_y, 0);
    endtask

    int arc[16] = '{8, 15, 21, 26, 30, 33, 35, 36, 35, 33, 30, 26, 21, 15, 8, 0};
`ifdef DINO_JUMP_CUT_EN
    int tail[7] = '{21, 20, 18, 15, 11, 6, 0};
`else
    int tail[13] = '{26, 30, 33, 35, 36, 35, 33, 30, 26, 21, 15, 8, 0};
`endif

    initial begin
        int bad_pulse;
        int peak;
        rst_n    = 1'b0;
        tick     = 1'b0;
        run      = 1'b0;
        jump_btn = 1'b0;
        duck_btn = 1'b0;

        // 1: reset state, then idle ticks
        repeat (2) @(negedge clk);
        check("rst y", dino_y, 0);
        check("rst air", airborne, 0);
        check("rst duck", ducking, 0);
        check("rst pulses", {jump_pulse, land_pulse}, 0);
        rst_n = 1'b1;
        run   = 1'b1;
        bad_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick1();
            if (dino_y != 0 || airborne || ducking || jump_pulse || land_pulse) bad_pulse++;
        end
        check("idle 10 ticks", bad_pulse, 0);

        // 2: full arc with held button
        launch("arc");
        for (int i = 0; i < 16; i++) begin
            tick1();
            check($sformatf("arc y t%0d", i + 1), dino_y, arc[i]);
            check($sformatf("arc land t%0d", i + 1), land_pulse, (i == 15) ? 1 : 0);
            check($sformatf("arc air t%0d", i + 1), airborne, (i < 15) ? 1 : 0);
            check($sformatf("arc jp t%0d", i + 1), jump_pulse, 0);
        end
        @(negedge clk);
        check("land pulse one clk", land_pulse, 0);
        repeat (2) begin
            tick1();
            check("held no retrigger jp", jump_pulse, 0);
            check("held no retrigger air", airborne, 0);
        end
        jump_btn = 1'b0;

        // 3: duck, jumps ignored while ducking
        @(negedge clk) duck_btn = 1'b1;
        tick1();
        check("duck enter", ducking, 1);
        @(negedge clk) jump_btn = 1'b1;
        tick1();
        check("duck jump ignored jp", jump_pulse, 0);
        check("duck jump ignored st", {airborne, ducking}, 2'b01);
        duck_btn = 1'b0;
        tick1();
        check("duck release st", {airborne, ducking}, 2'b00);
        check("duck release jp", jump_pulse, 0);
        tick1();
        check("duck no late jump", {airborne, jump_pulse}, 2'b00);
        jump_btn = 1'b0;

        // 4: jump and duck on the same tick, tick held two clocks
        @(negedge clk);
        jump_btn = 1'b1;
        duck_btn = 1'b1;
        tick     = 1'b1;
        @(negedge clk);
        check("both jp", jump_pulse, 1);
        check("both st", {airborne, ducking}, 2'b10);
        @(negedge clk) tick = 1'b0;
        check("tick held pulse drop", jump_pulse, 0);
        check("tick held y", dino_y, 8);
        duck_btn = 1'b0;
        for (int i = 1; i < 16; i++) tick1();
        check("both landed", {airborne, land_pulse, dino_y}, {2'b01, 6'd0});

        // 5: run freeze mid-air, then reset while falling
        jump_btn = 1'b0;
        @(negedge clk);
        launch("frz");
        for (int i = 0; i < 5; i++) tick1();
        check("frz y30", dino_y, 30);
        run = 1'b0;
        for (int i = 0; i < 5; i++) tick1();
        check("frz hold y", dino_y, 30);
        check("frz hold air", airborne, 1);
        run = 1'b1;
        for (int i = 5; i < 13; i++) begin
            tick1();
            check($sformatf("frz resume t%0d", i + 1), dino_y, arc[i]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        jump_btn = 1'b0;
        #1;
        check("rst mid-air y", dino_y, 0);
        check("rst mid-air st", {airborne, land_pulse, jump_pulse}, 3'b000);
        @(negedge clk) rst_n = 1'b1;

        // 6: release after three rising ticks
        @(negedge clk);
        launch("cut");
        for (int i = 0; i < 3; i++) tick1();
        check("cut y21", dino_y, 21);
        jump_btn = 1'b0;
        peak = 0;
        for (int i = 0; i < $size(tail); i++) begin
            tick1();
            if (int'(dino_y) > peak) peak = int'(dino_y);
            check($sformatf("cut y t%0d", i + 1), dino_y, tail[i]);
            check($sformatf("cut land t%0d", i + 1), land_pulse, (i == $size(tail) - 1) ? 1 : 0);
        end
`ifdef DINO_JUMP_CUT_EN
        check("cut peak", peak, 21);
`else
        check("cut peak", peak, 36);
`endif
        check("cut end air", airborne, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
